bus_master_port: RTL and testbench
==================================

Name: bus_master_port

Overview:
- Initiator end of the serial single-bit bus; the storage slave is the responder.
- Accepts parallel read/write requests from a host, serialises address and write data onto the bus, waits out the slave read latency, and deserialises read data back to the host.
- One instance per bus master, sitting between the host logic and the bus arbiter/slave.

Parameters:
- N, 8, data word width in bits.
- ADN, 12, address width in bits; requires ADN >= N.
- TIMEOUT, 1023, maximum cycles to wait for slave read data before flagging an error.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- reset  in  1  synchronous, active-low reset; reset=0 at a rising edge resets the block.
- req  in  1  host request strobe; sampled only in IDLE.
- req_wren  in  1  1 = write, 0 = read; captured with req.
- req_addr  in  ADN  target address; captured with req.
- req_wdata  in  N  write data; captured with req.
- rd_ready  in  1  host can accept read data; drives bus_available.
- req_ack  out  1  one-cycle pulse: request captured.
- busy  out  1  high in every state except IDLE.
- rd_valid  out  1  one-cycle pulse: rd_data valid.
- rd_data  out  N  last read word; held until the next read completes.
- err  out  1  one-cycle pulse: read timeout.
- validOut  out  1  to slave validIn.
- wren  out  1  to slave wren.
- Address  out  1  serial address bit, MSB first.
- DataOut  out  1  serial write-data bit, MSB first.
- BurstEn  out  1  tied 0; this block does single transfers only.
- bus_available  out  1  to slave BusAvailable.
- slave_ready  in  1  from slave ready.
- slave_hold  in  1  from slave hold.
- slave_valid  in  1  from slave validOut.
- slave_data  in  1  from slave DataOut.

Behaviour:
- Reset values: all outputs 0, state IDLE, shift registers and counters 0. Reset overrides every state, including mid-transfer.
- States: IDLE, REQ, ADDR, WR_END, RD_WAIT, RD_DATA.
- IDLE:
  - If req=1: capture addr/wdata/wren into shift registers, pulse req_ack, go to REQ.
  - req arriving while busy=1 is ignored; the host must hold it.
- REQ, one cycle:
  - validOut=1, wren=captured value, Address=0, DataOut=0.
  - This cycle lets the slave leave its idle state. Go to ADDR.
- ADDR, exactly ADN cycles (bit counter 0..ADN-1):
  - validOut=1, wren held, Address = addr MSB first.
  - Write only: when counter >= ADN-N, DataOut = wdata MSB first, so data bit 0 (MSB) coincides with address bit ADN-N. Otherwise DataOut=0.
  - After the last bit: write goes to WR_END, read goes to RD_WAIT.
- WR_END:
  - validOut=0, wren=0.
  - Wait for slave_ready=1, then one further cycle, then go to IDLE. The gap guarantees the slave has returned to idle before the next REQ.
- RD_WAIT:
  - validOut=0, wren=0, bus_available=rd_ready.
  - Timeout counter increments every cycle; slave_hold is informational only.
  - On slave_valid=1: go to RD_DATA. This first valid cycle is a preamble and carries no data.
  - If the counter reaches TIMEOUT: pulse err, go to IDLE, leave rd_data unchanged.
- RD_DATA, exactly N cycles:
  - Shift in slave_data MSB first: shift register {sr[N-2:0], slave_data}.
  - After the N-th bit: rd_data <= sr, pulse rd_valid on the following cycle, go to IDLE.
  - If slave_valid drops early: pulse err, go to IDLE, leave rd_data unchanged.
- bus_available is 0 outside RD_WAIT and RD_DATA; in RD_DATA it equals 1.
- Write latency: req to IDLE = 1 + ADN + WR_END wait + 1 cycles.
- Read latency: ADN + 2 + slave delay + 1 + N cycles.
- Back-to-back requests: req may be high in the same cycle the block returns to IDLE; it is accepted at that edge.
- Counters are sized $clog2(ADN+1) and $clog2(TIMEOUT+1) bits; no wrap-around occurs within a transfer.

Test Plan:
- Write addr=0xA5C, wdata=0x3C -> REQ cycle, then Address bits 1010_0101_1100 over 12 cycles; DataOut=0 for the first 4, then 0011_1100; against the slave model, memory[0xA5C]=0x3C.
- Read back 0xA5C with rd_ready=1 and slave delay 20 -> preamble cycle discarded, rd_data=0x3C, single rd_valid pulse, busy falls the next cycle.
- Read with rd_ready=0 for 50 cycles after the delay expires -> bus_available=0 and slave stays holding; raise rd_ready -> data 0x3C arrives, no err.
- Read to a slave that never responds, TIMEOUT=100 -> err pulses exactly 101 cycles after entering RD_WAIT, rd_data unchanged, block returns to IDLE.
- reset=0 midway through ADDR of a write -> next edge: all outputs 0, state IDLE; a following write of 0x55 to 0x001 completes correctly.
- req held high continuously: write then read -> exactly one req_ack per transfer, no overlap of validOut between transfers, gap of at least 1 cycle after WR_END.

Source files
------------

// File: rtl/bus_master_port.sv
// bus_master_port: initiator end of the single-bit serial storage bus.
// Takes one parallel read or write request at a time from the host. It sends
// the address (and the write data, for writes) onto the bus MSB first. For a
// read it waits for the slave's reply and returns the deserialised word.
//
// Ports
//   clk, reset        rising-edge clock, synchronous active-low reset
//   req, req_wren     host request strobe (sampled in idle only), 1 = write
//   req_addr          target address (ADN bits)
//   req_wdata         write data (N bits)
//   rd_ready          host can take read data; forwarded as bus_available
//   req_ack           one-cycle pulse when a request is captured
//   busy              high whenever a transfer is in progress
//   rd_valid          one-cycle pulse, rd_data holds a fresh word
//   rd_data           last successfully read word
//   err               one-cycle pulse on read timeout or truncated read data
//   validOut, wren    bus control to the slave
//   Address, DataOut  serial address / write-data bits, MSB first
//   BurstEn           always 0, single transfers only
//   bus_available     to slave BusAvailable
//   slave_ready       slave has finished a write
//   slave_hold        slave is stalled on bus_available (informational)
//   slave_valid       slave serial data qualifier (first cycle is a preamble)
//   slave_data        slave serial read data, MSB first
module bus_master_port #(
   parameter int unsigned N       = 8,
   parameter int unsigned ADN     = 12,
   parameter int unsigned TIMEOUT = 1023
) (
   input  logic           clk,
   input  logic           reset,
   input  logic           req,
   input  logic           req_wren,
   input  logic [ADN-1:0] req_addr,
   input  logic [N-1:0]   req_wdata,
   input  logic           rd_ready,
   output logic           req_ack,
   output logic           busy,
   output logic           rd_valid,
   output logic [N-1:0]   rd_data,
   output logic           err,
   output logic           validOut,
   output logic           wren,
   output logic           Address,
   output logic           DataOut,
   output logic           BurstEn,
   output logic           bus_available,
   input  logic           slave_ready,
   input  logic           slave_hold,
   input  logic           slave_valid,
   input  logic           slave_data
);

   localparam int unsigned BitCntW = $clog2(ADN + 1);
   localparam int unsigned ToCntW  = $clog2(TIMEOUT + 1);

   localparam logic [BitCntW-1:0] LastAddrBit  = BitCntW'(ADN - 1);
   localparam logic [BitCntW-1:0] DataStartBit = BitCntW'(ADN - N);
   localparam logic [BitCntW-1:0] LastDataBit  = BitCntW'(N - 1);
   localparam logic [ToCntW-1:0]  ToMax        = ToCntW'(TIMEOUT);

   typedef enum logic [2:0] {
      StIdle,
      StReq,
      StAddr,
      StWrEnd,
      StRdWait,
      StRdData
   } state_t;

   state_t             state;
   logic [ADN-1:0]     addrSr;
   logic [N-1:0]       dataSr;   // write data out, or read data in
   logic               isWrite;
   logic               wrGap;    // slave_ready seen, one settling cycle left
   logic [BitCntW-1:0] bitCnt;
   logic [ToCntW-1:0]  toCnt;

   logic unused_slave_hold;
   assign unused_slave_hold = slave_hold;

   assign BurstEn = 1'b0;

   // Follows rd_ready combinationally so the slave sees host back-pressure
   // without an extra cycle of latency.
   assign bus_available = (state == StRdData) || ((state == StRdWait) && rd_ready);

   always_ff @(posedge clk) begin
      if (!reset) begin
         state    <= StIdle;
         addrSr   <= '0;
         dataSr   <= '0;
         isWrite  <= 1'b0;
         wrGap    <= 1'b0;
         bitCnt   <= '0;
         toCnt    <= '0;
         req_ack  <= 1'b0;
         busy     <= 1'b0;
         rd_valid <= 1'b0;
         rd_data  <= '0;
         err      <= 1'b0;
         validOut <= 1'b0;
         wren     <= 1'b0;
         Address  <= 1'b0;
         DataOut  <= 1'b0;
      end else begin
         req_ack  <= 1'b0;
         rd_valid <= 1'b0;
         err      <= 1'b0;

         unique case (state)
            StIdle: begin
               if (req) begin
                  addrSr   <= req_addr;
                  dataSr   <= req_wdata;
                  isWrite  <= req_wren;
                  req_ack  <= 1'b1;
                  busy     <= 1'b1;
                  validOut <= 1'b1;
                  wren     <= req_wren;
                  Address  <= 1'b0;
                  DataOut  <= 1'b0;
                  bitCnt   <= '0;
                  state    <= StReq;
               end
            end

            StReq: begin
               Address <= addrSr[ADN-1];
               addrSr  <= addrSr << 1;
               // When ADN == N the data starts together with the first address bit.
               if (isWrite && (DataStartBit == '0)) begin
                  DataOut <= dataSr[N-1];
                  dataSr  <= dataSr << 1;
               end
               bitCnt <= '0;
               state  <= StAddr;
            end

            StAddr: begin
               if (bitCnt == LastAddrBit) begin
                  validOut <= 1'b0;
                  wren     <= 1'b0;
                  Address  <= 1'b0;
                  DataOut  <= 1'b0;
                  wrGap    <= 1'b0;
                  toCnt    <= '0;
                  state    <= isWrite ? StWrEnd : StRdWait;
               end else begin
                  Address <= addrSr[ADN-1];
                  addrSr  <= addrSr << 1;
                  // bitCnt + 1 is the index of the bit being put on the bus next.
                  if (isWrite && ((bitCnt + BitCntW'(1)) >= DataStartBit)) begin
                     DataOut <= dataSr[N-1];
                     dataSr  <= dataSr << 1;
                  end else begin
                     DataOut <= 1'b0;
                  end
                  bitCnt <= bitCnt + BitCntW'(1);
               end
            end

            StWrEnd: begin
               if (wrGap) begin
                  busy  <= 1'b0;
                  state <= StIdle;
               end else if (slave_ready) begin
                  wrGap <= 1'b1;
               end
            end

            StRdWait: begin
               // The first valid cycle is a preamble; data bits follow it.
               if (slave_valid) begin
                  bitCnt <= '0;
                  state  <= StRdData;
               end else if (toCnt == ToMax) begin
                  err   <= 1'b1;
                  busy  <= 1'b0;
                  state <= StIdle;
               end else begin
                  toCnt <= toCnt + ToCntW'(1);
               end
            end

            StRdData: begin
               if (!slave_valid) begin
                  err   <= 1'b1;
                  busy  <= 1'b0;
                  state <= StIdle;
               end else begin
                  dataSr <= {dataSr[N-2:0], slave_data};
                  if (bitCnt == LastDataBit) begin
                     rd_data  <= {dataSr[N-2:0], slave_data};
                     rd_valid <= 1'b1;
                     busy     <= 1'b0;
                     state    <= StIdle;
                  end else begin
                     bitCnt <= bitCnt + BitCntW'(1);
                  end
               end
            end

            default: state <= StIdle;
         endcase
      end
   end

endmodule

// File: tb/tb_bus_master_port.sv
module tb_bus_master_port;

   localparam int N       = 8;
   localparam int ADN     = 12;
   localparam int TIMEOUT = 100;

   logic           clk;
   logic           reset;
   logic           req;
   logic           req_wren;
   logic [ADN-1:0] req_addr;
   logic [N-1:0]   req_wdata;
   logic           rd_ready;
   logic           req_ack;
   logic           busy;
   logic           rd_valid;
   logic [N-1:0]   rd_data;
   logic           err;
   logic           validOut;
   logic           wren;
   logic           Address;
   logic           DataOut;
   logic           BurstEn;
   logic           bus_available;
   logic           slave_ready;
   logic           slave_hold;
   logic           slave_valid;
   logic           slave_data;

   bus_master_port #(
      .N      (N),
      .ADN    (ADN),
      .TIMEOUT(TIMEOUT)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .req          (req),
      .req_wren     (req_wren),
      .req_addr     (req_addr),
      .req_wdata    (req_wdata),
      .rd_ready     (rd_ready),
      .req_ack      (req_ack),
      .busy         (busy),
      .rd_valid     (rd_valid),
      .rd_data      (rd_data),
      .err          (err),
      .validOut     (validOut),
      .wren         (wren),
      .Address      (Address),
      .DataOut      (DataOut),
      .BurstEn      (BurstEn),
      .bus_available(bus_available),
      .slave_ready  (slave_ready),
      .slave_hold   (slave_hold),
      .slave_valid  (slave_valid),
      .slave_data   (slave_data)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;

   // Slave storage, filled only from what the DUT serialises on the bus.
   logic [N-1:0] slaveMem [int];
   // Host-side golden memory: what the host intended to write.
   logic [N-1:0] refMem [int];
   logic [N-1:0] expLast;  // word rd_data must hold after the last good read

   logic [ADN-1:0] obsAddr;
   logic [N-1:0]   obsData;
   logic [N-1:0]   obsRd;
   int             protoBad;
   int             waitCycles;
   bit             sawErr;
   bit             sawValid;

   // Host write plus slave behaviour; records what the slave received.
   task automatic bus_write(input logic [ADN-1:0] a, input logic [N-1:0] d,
                            input int rdyDelay, input bit holdReq);
      protoBad = 0;
      obsAddr  = '0;
      obsData  = '0;
      req = 1'b1; req_wren = 1'b1; req_addr = a; req_wdata = d;
      @(negedge clk);
      if (!(req_ack === 1'b1 && busy === 1'b1 && validOut === 1'b1 && wren === 1'b1 &&
            Address === 1'b0 && DataOut === 1'b0)) protoBad++;
      if (!holdReq) req = 1'b0;
      for (int k = 0; k < ADN; k++) begin
         @(negedge clk);
         if (validOut !== 1'b1 || wren !== 1'b1 || req_ack !== 1'b0 || bus_available !== 1'b0)
            protoBad++;
         obsAddr[ADN-1-k] = Address;
         if (k >= ADN - N) obsData[N-1-(k-(ADN-N))] = DataOut;
         else if (DataOut !== 1'b0) protoBad++;
      end
      for (int i = 0; i <= rdyDelay; i++) begin
         @(negedge clk);
         if (validOut !== 1'b0 || wren !== 1'b0 || busy !== 1'b1 || req_ack !== 1'b0) protoBad++;
      end
      slave_ready = 1'b1;
      @(negedge clk);
      slave_ready = 1'b0;
      if (busy !== 1'b1 || validOut !== 1'b0 || req_ack !== 1'b0) protoBad++;
      @(negedge clk);
      if (busy !== 1'b0 || validOut !== 1'b0 || req_ack !== 1'b0) protoBad++;
      slaveMem[int'(obsAddr)] = obsData;
   endtask

   // Host read plus slave behaviour: latency, optional hold on bus_available,
   // preamble, then N data bits. mute = slave never answers.
   task automatic bus_read(input logic [ADN-1:0] a, input int delay, input int holdCycles,
                           input bit mute, input bit holdReq);
      logic [N-1:0] word;
      protoBad = 0; obsAddr = '0; waitCycles = 0; sawErr = 0; sawValid = 0; obsRd = '0;
      rd_ready = (holdCycles == 0);
      req = 1'b1; req_wren = 1'b0; req_addr = a; req_wdata = N'($urandom);
      @(negedge clk);
      if (!(req_ack === 1'b1 && busy === 1'b1 && validOut === 1'b1 && wren === 1'b0 &&
            Address === 1'b0 && DataOut === 1'b0)) protoBad++;
      if (!holdReq) req = 1'b0;
      for (int k = 0; k < ADN; k++) begin
         @(negedge clk);
         if (validOut !== 1'b1 || wren !== 1'b0 || DataOut !== 1'b0 || req_ack !== 1'b0) protoBad++;
         obsAddr[ADN-1-k] = Address;
      end
      for (int i = 0; i < delay; i++) begin
         @(negedge clk);
         waitCycles++;
         if (validOut !== 1'b0 || wren !== 1'b0 || busy !== 1'b1 || err !== 1'b0 ||
             bus_available !== rd_ready) protoBad++;
      end
      if (mute) begin
         while (!sawErr && waitCycles < TIMEOUT + 20) begin
            @(negedge clk);
            waitCycles++;
            if (err === 1'b1) sawErr = 1;
            else if (busy !== 1'b1 || bus_available !== rd_ready) protoBad++;
         end
         req = 1'b0;
         return;
      end
      if (holdCycles > 0) begin
         slave_hold = 1'b1;
         for (int i = 0; i < holdCycles; i++) begin
            @(negedge clk);
            waitCycles++;
            if (bus_available !== 1'b0 || busy !== 1'b1 || err !== 1'b0) protoBad++;
         end
         rd_ready = 1'b1;
         @(negedge clk);
         waitCycles++;
         if (bus_available !== 1'b1 || busy !== 1'b1) protoBad++;
         slave_hold = 1'b0;
      end
      word = slaveMem.exists(int'(obsAddr)) ? slaveMem[int'(obsAddr)] : '0;
      slave_valid = 1'b1;
      slave_data  = 1'($urandom);  // preamble carries junk
      @(negedge clk);
      if (busy !== 1'b1 || bus_available !== 1'b1 || rd_valid !== 1'b0) protoBad++;
      for (int b = 0; b < N; b++) begin
         slave_data = word[N-1-b];
         @(negedge clk);
         if (b < N - 1) begin
            if (rd_valid !== 1'b0 || busy !== 1'b1 || bus_available !== 1'b1 || err !== 1'b0)
               protoBad++;
         end else begin
            sawValid = (rd_valid === 1'b1);
            obsRd    = rd_data;
            if (busy !== 1'b0 || err !== 1'b0) protoBad++;
         end
      end
      req = 1'b0;
      slave_valid = 1'b0;
      slave_data  = 1'b0;
      @(negedge clk);
      if (rd_valid !== 1'b0 || err !== 1'b0 || busy !== 1'b0) protoBad++;
   endtask

   task automatic test_reset();
      reset = 1'b0; req = 1'b0; req_wren = 1'b0; req_addr = '0; req_wdata = '0;
      rd_ready = 1'b0; slave_ready = 1'b0; slave_hold = 1'b0; slave_valid = 1'b0;
      slave_data = 1'b0;
      repeat (3) @(negedge clk);
      checks++;
      if ({req_ack, busy, rd_valid, rd_data, err, validOut, wren, Address, DataOut, BurstEn,
           bus_available} !== '0) begin
         errors++;
         $display("FAIL reset_outputs: got busy=%b rd_data=%0h validOut=%b required all 0",
                  busy, rd_data, validOut);
      end
      reset = 1'b1;
      @(negedge clk);
      expLast = '0;
   endtask

   task automatic test_write();
      bus_write(12'hA5C, 8'h3C, 3, 0);
      refMem[12'hA5C] = 8'h3C;
      checks++;
      if (obsAddr !== 12'hA5C) begin
         errors++; $display("FAIL write_addr: got %h required a5c", obsAddr);
      end
      checks++;
      if (obsData !== 8'h3C) begin
         errors++; $display("FAIL write_data: got %h required 3c", obsData);
      end
      checks++;
      if (protoBad !== 0) begin
         errors++; $display("FAIL write_protocol: got %0d bad cycles required 0", protoBad);
      end
      checks++;
      if (slaveMem[12'hA5C] !== 8'h3C) begin
         errors++; $display("FAIL write_slave_mem: got %h required 3c", slaveMem[12'hA5C]);
      end
   endtask

   task automatic test_read();
      bus_read(12'hA5C, 20, 0, 0, 0);
      expLast = refMem[12'hA5C];
      checks++;
      if (obsRd !== 8'h3C) begin
         errors++; $display("FAIL read_data: got %h required 3c", obsRd);
      end
      checks++;
      if (!sawValid) begin
         errors++; $display("FAIL read_valid: got rd_valid=0 required 1");
      end
      checks++;
      if (protoBad !== 0 || obsAddr !== 12'hA5C) begin
         errors++;
         $display("FAIL read_protocol: got %0d bad cycles addr %h required 0 / a5c",
                  protoBad, obsAddr);
      end
   endtask

   task automatic test_read_hold();
      bus_read(12'hA5C, 20, 50, 0, 0);
      checks++;
      if (obsRd !== refMem[12'hA5C] || !sawValid) begin
         errors++;
         $display("FAIL hold_data: got %h valid=%b required %h valid=1",
                  obsRd, sawValid, refMem[12'hA5C]);
      end
      checks++;
      if (protoBad !== 0) begin
         errors++; $display("FAIL hold_protocol: got %0d bad cycles required 0", protoBad);
      end
   endtask

   task automatic test_timeout();
      bus_read(12'h123, 0, 0, 1, 0);
      checks++;
      if (!sawErr) begin
         errors++; $display("FAIL timeout_err: got no err pulse required one");
      end
      // waitCycles counts negedges after entry; edges after entry is one less.
      checks++;
      if (waitCycles - 1 !== TIMEOUT + 1) begin
         errors++;
         $display("FAIL timeout_cycles: got %0d required %0d", waitCycles - 1, TIMEOUT + 1);
      end
      checks++;
      if (busy !== 1'b0 || rd_valid !== 1'b0 || protoBad !== 0) begin
         errors++;
         $display("FAIL timeout_state: got busy=%b rd_valid=%b bad=%0d required 0/0/0",
                  busy, rd_valid, protoBad);
      end
      checks++;
      if (rd_data !== expLast) begin
         errors++; $display("FAIL timeout_rd_data: got %h required %h", rd_data, expLast);
      end
      @(negedge clk);
      checks++;
      if (err !== 1'b0) begin
         errors++; $display("FAIL timeout_pulse: got err=%b required 0", err);
      end
   endtask

   task automatic test_reset_midway();
      req = 1'b1; req_wren = 1'b1; req_addr = 12'h3F0; req_wdata = 8'hAA;
      @(negedge clk);
      req = 1'b0;
      repeat (5) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      checks++;
      if ({req_ack, busy, rd_valid, rd_data, err, validOut, wren, Address, DataOut, BurstEn,
           bus_available} !== '0) begin
         errors++;
         $display("FAIL midreset_outputs: got busy=%b validOut=%b wren=%b rd_data=%h required 0",
                  busy, validOut, wren, rd_data);
      end
      reset = 1'b1;
      expLast = '0;
      @(negedge clk);
      bus_write(12'h001, 8'h55, 1, 0);
      refMem[12'h001] = 8'h55;
      checks++;
      if (obsAddr !== 12'h001 || obsData !== 8'h55 || protoBad !== 0) begin
         errors++;
         $display("FAIL midreset_write: got %h/%h bad=%0d required 001/55/0",
                  obsAddr, obsData, protoBad);
      end
      bus_read(12'h001, 5, 0, 0, 0);
      checks++;
      if (obsRd !== refMem[12'h001] || protoBad !== 0) begin
         errors++;
         $display("FAIL midreset_read: got %h bad=%0d required 55/0", obsRd, protoBad);
      end
   endtask

   task automatic test_back_to_back();
      int badW;
      bus_write(12'h7E1, 8'hC3, 2, 1);
      refMem[12'h7E1] = 8'hC3;
      badW = protoBad;
      checks++;
      if (badW !== 0 || obsData !== 8'hC3) begin
         errors++;
         $display("FAIL b2b_write: got bad=%0d data=%h required 0/c3", badW, obsData);
      end
      bus_read(12'h7E1, 7, 0, 0, 1);
      checks++;
      if (protoBad !== 0 || obsAddr !== 12'h7E1) begin
         errors++;
         $display("FAIL b2b_read_protocol: got bad=%0d addr=%h required 0/7e1",
                  protoBad, obsAddr);
      end
      checks++;
      if (obsRd !== refMem[12'h7E1]) begin
         errors++; $display("FAIL b2b_read_data: got %h required c3", obsRd);
      end
   endtask

   task automatic test_random();
      logic [ADN-1:0] wq [$];
      logic [ADN-1:0] a;
      logic [N-1:0]   d;
      for (int it = 0; it < 6; it++) begin
         a = ADN'($urandom);
         d = N'($urandom);
         bus_write(a, d, int'($urandom_range(0, 5)), 0);
         refMem[int'(a)] = d;
         wq.push_back(a);
         checks++;
         if (obsAddr !== a || obsData !== d || protoBad !== 0) begin
            errors++;
            $display("FAIL rand_write_%0d: got %h/%h bad=%0d required %h/%h/0",
                     it, obsAddr, obsData, protoBad, a, d);
         end
         a = wq[$urandom_range(0, wq.size() - 1)];
         bus_read(a, int'($urandom_range(0, 30)), int'($urandom_range(0, 20)), 0, 0);
         checks++;
         if (obsRd !== refMem[int'(a)] || !sawValid || protoBad !== 0) begin
            errors++;
            $display("FAIL rand_read_%0d: addr %h got %h valid=%b bad=%0d required %h",
                     it, a, obsRd, sawValid, protoBad, refMem[int'(a)]);
         end
      end
   endtask

   initial begin
      test_reset();
      test_write();
      test_read();
      test_read_hold();
      test_timeout();
      test_reset_midway();
      test_back_to_back();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
